// File: rtl/deadlock_pkg.sv
// Shared types and constants for the deadlock watchdog: FSM encoding,
// report field widths and the default detection threshold.
package deadlock_pkg;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int CH_IDX_W        = 3;
    localparam int CYC_W           = 16;
    localparam int STATE_W         = 3;

    // These values are also what state_dbg exposes to software.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_COUNTING = 3'd2,
        ST_DEADLOCK = 3'd3,
        ST_REPORT   = 3'd4,
        ST_HOLD     = 3'd5
    } wd_state_e;

endpackage

// File: rtl/prio_next_set.sv
// Combinational finder: lowest set bit of i_vec whose index is >= i_start.
// An i_start beyond the top bit simply yields o_found = 0.
module prio_next_set
    import deadlock_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0]        i_vec,
    input  logic [CH_IDX_W:0]   i_start,
    output logic                o_found,
    output logic [CH_IDX_W-1:0] o_idx
);

    // NOTE: every output gets a default before the loop, otherwise the
    // paths where no bit matches would infer a latch.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Descending scan so the lowest qualifying index is written last.
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i] && (i >= int'(i_start))) begin
                o_found = 1'b1;
                o_idx   = CH_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/deadlock_watchdog_ctrl.sv
// Deadlock watchdog: counts consecutive cycles with any qualified blocked
// stream, freezes a channel snapshot on timeout and reports each channel.
module deadlock_watchdog_ctrl
    import deadlock_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [NUM_CH-1:0]   axis_block_sigs,
    input  logic [NUM_CH-1:0]   inst_idle_sigs,
    input  logic                report_ready,
    output logic                block,
    output logic [NUM_CH-1:0]   blocked_mask,
    output logic                report_valid,
    output logic [CH_IDX_W-1:0] report_ch,
    output logic [CYC_W-1:0]    report_cycles,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);

    wd_state_e           r_state;
    wd_state_e           w_state_next;
    logic [CYC_W-1:0]    r_cnt;
    logic [CYC_W-1:0]    r_cyc;
    logic [NUM_CH-1:0]   r_mask;
    logic [CH_IDX_W-1:0] r_ptr;

    logic [NUM_CH-1:0]   w_qb;
    logic                w_any_blk;
    logic [CYC_W-1:0]    w_cnt_inc;
    logic                w_hit;
    logic                w_abandon;
    logic                w_handshake;
    logic [CH_IDX_W:0]   w_start;
    logic                w_found;
    logic [CH_IDX_W-1:0] w_idx;

    assign w_qb        = axis_block_sigs & ~inst_idle_sigs;
    assign w_any_blk   = |w_qb;
    assign w_cnt_inc   = r_cnt + CYC_W'(1);
    // r_cnt holds blocked cycles already seen; this cycle makes the count w_cnt_inc.
    assign w_hit       = w_any_blk && (w_cnt_inc == TIMEOUT_C);
    assign w_abandon   = clear && (r_state != ST_IDLE);
    assign w_handshake = (r_state == ST_REPORT) && report_ready;

    // First report scans from bit 0; later ones from just above the pointer.
    assign w_start = (r_state == ST_DEADLOCK) ? '0 : ({1'b0, r_ptr} + 1'b1);

    prio_next_set #(
        .W (NUM_CH)
    ) u_prio_next_set (
        .i_vec   (r_mask),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // enable low outranks clear, which outranks any detection this cycle.
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else if (w_abandon) begin
            w_state_next = ST_ARMED;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_next = ST_ARMED;
                ST_ARMED:    if (w_any_blk) w_state_next = ST_COUNTING;
                ST_COUNTING: begin
                    if (!w_any_blk) begin
                        w_state_next = ST_ARMED;
                    end else if (w_hit) begin
                        w_state_next = ST_DEADLOCK;
                    end
                end
                ST_DEADLOCK: w_state_next = ST_REPORT;
                ST_REPORT:   if (w_handshake && !w_found) w_state_next = ST_HOLD;
                ST_HOLD:     w_state_next = ST_HOLD;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || !enable || w_abandon) begin
            r_cnt  <= '0;
            r_cyc  <= '0;
            r_mask <= '0;
            r_ptr  <= '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_any_blk) r_cnt <= CYC_W'(1);
                end
                ST_COUNTING: begin
                    if (!w_any_blk) begin
                        r_cnt <= '0;
                    end else if (w_hit) begin
                        r_cnt  <= w_cnt_inc;
                        r_cyc  <= w_cnt_inc;
                        r_mask <= w_qb;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DEADLOCK: r_ptr <= w_idx;
                ST_REPORT: begin
                    if (w_handshake && w_found) r_ptr <= w_idx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        block        = 1'b0;
        report_valid = 1'b0;
        case (r_state)
            ST_DEADLOCK,
            ST_HOLD:   block = 1'b1;
            ST_REPORT: begin
                block        = 1'b1;
                report_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign blocked_mask  = r_mask;
    assign report_ch     = r_ptr;
    assign report_cycles = r_cyc;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_deadlock_watchdog_ctrl.sv
// Directed plus randomized bench for deadlock_watchdog_ctrl, compared each
// cycle against a run-length / report-queue reference model.
module tb_deadlock_watchdog_ctrl;

    localparam int NCH = 5;
    localparam int TO  = 8;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_COUNTING = 3'd2;
    localparam logic [2:0] S_DEADLOCK = 3'd3;
    localparam logic [2:0] S_REPORT   = 3'd4;
    localparam logic [2:0] S_HOLD     = 3'd5;

    logic           ap_clk = 1'b0;
    logic           ap_rst_n;
    logic           enable;
    logic           clear;
    logic [NCH-1:0] axis_block_sigs;
    logic [NCH-1:0] inst_idle_sigs;
    logic           report_ready;
    logic           block;
    logic [NCH-1:0] blocked_mask;
    logic           report_valid;
    logic [2:0]     report_ch;
    logic [15:0]    report_cycles;
    logic [2:0]     state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: watchdog on/off, consecutive blocked run length,
    // deadlock flag, first-cycle flag and the queue of channels left to report.
    bit             m_on;
    bit             m_dl;
    bit             m_fresh;
    int             m_run;
    int             m_cyc;
    logic [NCH-1:0] m_mask;
    int             m_q[$];

    deadlock_watchdog_ctrl #(
        .NUM_CH  (NCH),
        .TIMEOUT (TO)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .enable          (enable),
        .clear           (clear),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .report_ready    (report_ready),
        .block           (block),
        .blocked_mask    (blocked_mask),
        .report_valid    (report_valid),
        .report_ch       (report_ch),
        .report_cycles   (report_cycles),
        .state_dbg       (state_dbg)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear_all();
        m_dl    = 1'b0;
        m_fresh = 1'b0;
        m_run   = 0;
        m_cyc   = 0;
        m_mask  = '0;
        m_q.delete();
    endtask

    task automatic model_step();
        logic [NCH-1:0] qb;
        if (!ap_rst_n || !enable) begin
            m_on = 1'b0;
            model_clear_all();
            return;
        end
        if (!m_on) begin
            m_on = 1'b1;
            return;
        end
        if (clear) begin
            model_clear_all();
            return;
        end
        if (m_dl) begin
            if (m_fresh) m_fresh = 1'b0;
            else if (m_q.size() > 0 && report_ready) void'(m_q.pop_front());
            return;
        end
        qb = axis_block_sigs & ~inst_idle_sigs;
        if (qb != '0) begin
            m_run++;
            if (m_run == TO) begin
                m_dl    = 1'b1;
                m_fresh = 1'b1;
                m_mask  = qb;
                m_cyc   = m_run;
                for (int c = 0; c < NCH; c++) if (qb[c]) m_q.push_back(c);
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check_model();
        logic [2:0] exp_state;
        bit         exp_valid;
        exp_valid = m_dl && !m_fresh && (m_q.size() > 0);
        if (!m_on)          exp_state = S_IDLE;
        else if (m_dl)      exp_state = m_fresh ? S_DEADLOCK : (exp_valid ? S_REPORT : S_HOLD);
        else if (m_run > 0) exp_state = S_COUNTING;
        else                exp_state = S_ARMED;
        check("m_state", 32'(state_dbg), 32'(exp_state));
        check("m_block", 32'(block), 32'(m_dl));
        check("m_mask", 32'(blocked_mask), m_dl ? 32'(m_mask) : 32'd0);
        check("m_valid", 32'(report_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("m_ch", 32'(report_ch), 32'(m_q[0]));
            check("m_cycles", 32'(report_cycles), 32'(m_cyc));
        end else if (!m_on) begin
            check("m_idle_ch", 32'(report_ch), 32'd0);
            check("m_idle_cycles", 32'(report_cycles), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_step();
        #1;
        check_model();
    endtask

    initial begin
        m_on = 1'b0;
        model_clear_all();
        ap_rst_n = 1'b0; enable = 1'b0; clear = 1'b0; report_ready = 1'b0;
        axis_block_sigs = '0; inst_idle_sigs = '0;
        tick(); tick();
        check("rst_state", 32'(state_dbg), 32'(S_IDLE));
        check("rst_block", 32'(block), 32'd0);
        check("rst_valid", 32'(report_valid), 32'd0);
        check("rst_cycles", 32'(report_cycles), 32'd0);

        ap_rst_n = 1'b1; enable = 1'b1;
        tick();
        check("arm_state", 32'(state_dbg), 32'(S_ARMED));

        // Single channel blocked exactly TIMEOUT cycles.
        axis_block_sigs = 5'b00100;
        repeat (TO - 1) tick();
        check("d36_pre_block", 32'(block), 32'd0);
        tick();
        check("d36_block", 32'(block), 32'd1);
        check("d36_mask", 32'(blocked_mask), 32'b00100);
        check("d36_state", 32'(state_dbg), 32'(S_DEADLOCK));
        axis_block_sigs = '0; report_ready = 1'b1;
        tick();
        check("d36_valid", 32'(report_valid), 32'd1);
        check("d36_ch", 32'(report_ch), 32'd2);
        check("d36_cycles", 32'(report_cycles), 32'd8);
        tick();
        check("d36_hold", 32'(state_dbg), 32'(S_HOLD));
        check("d36_hold_valid", 32'(report_valid), 32'd0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_state", 32'(state_dbg), 32'(S_ARMED));
        check("clr_mask", 32'(blocked_mask), 32'd0);

        // Runs one short of the threshold never fire.
        axis_block_sigs = 5'b01000; repeat (TO - 1) tick();
        axis_block_sigs = '0; tick();
        check("d37_state1", 32'(state_dbg), 32'(S_ARMED));
        axis_block_sigs = 5'b01000; repeat (TO - 1) tick();
        check("d37_block", 32'(block), 32'd0);
        axis_block_sigs = '0; tick();
        check("d37_state2", 32'(state_dbg), 32'(S_ARMED));

        // Idle-qualified snapshot, stalled consumer, then streaming reports.
        axis_block_sigs = 5'b10110; inst_idle_sigs = 5'b00010; report_ready = 1'b0;
        repeat (TO) tick();
        check("d38_mask", 32'(blocked_mask), 32'b10100);
        axis_block_sigs = 5'b11111; inst_idle_sigs = '0;
        tick();
        check("d39_ch_first", 32'(report_ch), 32'd2);
        repeat (4) tick();
        check("d39_ch_stable", 32'(report_ch), 32'd2);
        check("d39_valid_stable", 32'(report_valid), 32'd1);
        report_ready = 1'b1;
        tick();
        check("d39_ch_next", 32'(report_ch), 32'd4);
        tick();
        check("d39_hold", 32'(state_dbg), 32'(S_HOLD));
        check("d39_mask_held", 32'(blocked_mask), 32'b10100);
        clear = 1'b1; axis_block_sigs = '0; tick(); clear = 1'b0; report_ready = 1'b0;

        // clear on the detecting cycle wins.
        axis_block_sigs = 5'b00001; repeat (TO - 1) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        check("d40_state", 32'(state_dbg), 32'(S_ARMED));
        check("d40_block", 32'(block), 32'd0);
        axis_block_sigs = '0; tick();

        // Reset mid-report, then enable low while holding.
        axis_block_sigs = 5'b00011; repeat (TO) tick();
        axis_block_sigs = '0; tick();
        check("d41_valid_pre", 32'(report_valid), 32'd1);
        ap_rst_n = 1'b0; tick();
        check("d41_rst_valid", 32'(report_valid), 32'd0);
        check("d41_rst_state", 32'(state_dbg), 32'(S_IDLE));
        ap_rst_n = 1'b1; tick();
        axis_block_sigs = 5'b00001; repeat (TO) tick();
        axis_block_sigs = '0; report_ready = 1'b1; tick(); tick();
        check("d41_hold", 32'(state_dbg), 32'(S_HOLD));
        enable = 1'b0; tick();
        check("d41_en_state", 32'(state_dbg), 32'(S_IDLE));
        check("d41_en_block", 32'(block), 32'd0);
        check("d41_en_mask", 32'(blocked_mask), 32'd0);
        enable = 1'b1; report_ready = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            ap_rst_n        = ($urandom_range(0, 499) != 0);
            enable          = ($urandom_range(0, 63) != 0);
            clear           = ($urandom_range(0, 79) == 0);
            axis_block_sigs = ($urandom_range(0, 5) == 0) ? '0 : NCH'($urandom);
            inst_idle_sigs  = NCH'($urandom & $urandom);
            report_ready    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/deadlock_watchdog_ctrl.md
DEADLOCK_WATCHDOG_CTRL -- requirements
Module: deadlock_watchdog_ctrl

Interface
REQ-001 Parameter NUM_CH, default 5, number of AXI-stream channels supervised (1..8).
REQ-002 Parameter TIMEOUT, default 1024, consecutive blocked cycles that declare deadlock (2..65535).
REQ-003 ap_clk  input  1  sole clock; all logic rising-edge.
REQ-004 ap_rst_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  watchdog armed when 1.
REQ-006 clear  input  1  one-cycle pulse; abandons detection or report, returns to ARMED.
REQ-007 axis_block_sigs  input  NUM_CH  per-channel stream-blocked flags.
REQ-008 inst_idle_sigs  input  NUM_CH  per-channel producer/consumer idle flags.
REQ-009 report_ready  input  1  consumer accepts current report.
REQ-010 block  output  1  deadlock declared, held until clear, enable low or reset.
REQ-011 blocked_mask  output  NUM_CH  channel snapshot latched at deadlock; 0 otherwise.
REQ-012 report_valid  output  1  report_ch/report_cycles valid.
REQ-013 report_ch  output  3  index of reported blocked channel.
REQ-014 report_cycles  output  16  blocked-cycle count at deadlock entry.
REQ-015 state_dbg  output  3  current FSM state encoding.

Function
REQ-016 Qualified block vector qb = axis_block_sigs & ~inst_idle_sigs; any_blk = OR(qb).
REQ-017 FSM states: IDLE, ARMED, COUNTING, DEADLOCK, REPORT, HOLD.
REQ-018 IDLE -> ARMED when enable=1; every state -> IDLE when enable=0, the cycle after it is sampled.
REQ-019 ARMED -> COUNTING when any_blk=1; 16-bit counter loaded with 1 on that transition.
REQ-020 COUNTING: counter +1 per cycle while any_blk=1; any_blk=0 -> ARMED with counter cleared.
REQ-021 COUNTING -> DEADLOCK in the cycle the counter equals TIMEOUT with any_blk still 1; blocked_mask <= qb, report_cycles <= counter, block <= 1 registered the same edge.
REQ-022 DEADLOCK lasts one cycle, then -> REPORT with scan pointer at lowest set bit of blocked_mask.
REQ-023 REPORT: report_valid=1, report_ch=pointer; report_ch/report_cycles stable while report_valid=1 and report_ready=0.
REQ-024 Handshake completes on report_valid&report_ready; pointer advances to next higher set bit next cycle; after last set bit -> HOLD, report_valid=0.
REQ-025 Back-to-back: report_ready held 1 yields one report per cycle, no bubbles.
REQ-026 HOLD: block=1, blocked_mask held, input blocking ignored.
REQ-027 clear=1 in any non-IDLE state -> ARMED next cycle; counter, block, blocked_mask, report_valid cleared; clear outranks same-cycle deadlock detection; enable=0 outranks clear.
REQ-028 Input changes after DEADLOCK entry do not alter blocked_mask or report order.
REQ-029 Counter never wraps; TIMEOUT <= 65535 guarantees detection before overflow.

Reset
REQ-030 ap_rst_n=0 sampled at a rising edge: state IDLE, counter 0, pointer 0, all outputs 0, state_dbg = IDLE encoding.
REQ-031 Reset mid-report drops report_valid the next cycle with no completing handshake.
REQ-032 No output becomes X after the first reset edge.

Structure
REQ-033 Shared package deadlock_pkg: FSM state enum, state_dbg encodings, default TIMEOUT, report field widths.
REQ-034 Single sub-module prio_next_set (combinational lowest-set-bit-at-or-above-index finder) used for pointer advance.
REQ-035 All registers in one always-block domain on ap_clk; no latches, no combinational loops.

Verification
REQ-036 TIMEOUT=8, axis_block_sigs=5'b00100 idle=0 for 8 cycles -> block=1 after the 8th blocked cycle, blocked_mask=00100, one report ch=2 cycles=8.
REQ-037 Block 7 cycles, release 1, block 7 cycles -> block stays 0, state returns ARMED each release.
REQ-038 axis_block_sigs=10110 with inst_idle_sigs=00010 -> qb=10100; reports ch=2 then ch=4; ch=1 never reported.
REQ-039 report_ready=0 for 5 cycles in REPORT -> report_ch=2 stable; then ready=1 continuous -> ch=4 next cycle, then HOLD.
REQ-040 clear pulsed in the same cycle counter reaches TIMEOUT -> no deadlock, block=0, state ARMED next cycle.
REQ-041 ap_rst_n=0 during REPORT -> report_valid=0, block=0, state IDLE next cycle; enable=0 in HOLD -> IDLE, outputs 0.
